jam_perm_scheduler: RTL and testbench
=====================================

// Module: jam_perm_scheduler
// PURPOSE
//  Sequencer for the job-assignment cost datapath. Steps through all N! worker->job
//  assignments in lexicographic order and issues one (W,J) cost-ROM address per beat
//  to the downstream cost accumulator / min-tracker. Frames each assignment with
//  perm_first/perm_last and pulses done after the final one.
// PARAMETERS
//  N      8  workers = jobs; legal 2..8
//  IDX_W  3  width of W/J indices
// PORTS
//  CLK         in   1      clock, rising edge
//  RST         in   1      synchronous, active-high reset
//  start       in   1      begin full enumeration; sampled only in IDLE
//  W           out  IDX_W  worker index of current beat
//  J           out  IDX_W  job index = perm[W]
//  addr_vld    out  1      W/J valid this cycle
//  addr_rdy    in   1      downstream accepts beat; beat transfers when addr_vld & addr_rdy
//  perm_first  out  1      beat is W=0 of an assignment
//  perm_last   out  1      beat is W=N-1 of an assignment
//  busy        out  1      state != IDLE
//  done        out  1      one-cycle pulse: all N! assignments issued
//  perm_cnt    out  16     assignments fully transferred (JAM_PERM_CNT_EN only)
// BEHAVIOUR
//  - Reset: W=0, J=0, addr_vld=0, perm_first=0, perm_last=0, busy=0, done=0, perm_cnt=0;
//    state IDLE; perm register = identity. Reset mid-run aborts immediately, no done.
//  - All outputs registered. States: IDLE, EMIT, NEXT, DONE.
//  - IDLE: start=1 -> load perm=identity (0..N-1), W=0, go EMIT. start ignored elsewhere.
//  - EMIT: addr_vld=1, J=perm[W], perm_first=(W==0), perm_last=(W==N-1).
//    No handshake -> W/J/flags held stable. Handshake and W<N-1 -> W+1, stay EMIT.
//    Handshake on W=N-1: perm is descending (N-1..0) -> DONE; else -> NEXT.
//  - NEXT: one cycle, addr_vld=0; perm <= next lexicographic permutation; W=0; -> EMIT.
//  - DONE: done=1, busy=1, addr_vld=0 for one cycle -> IDLE; start in DONE ignored.
//  - Timing at addr_rdy=1: start at cycle t -> first beat t+1; N+1 cycles per assignment;
//    N=8: 40320 assignments, 322560 beats, done at t+362880.
//  - Next-perm rule: pivot i = largest i with p[i]<p[i+1]; k = largest k>i with p[k]>p[i];
//    swap p[i],p[k]; reverse p[i+1..N-1]. Never invoked on the descending permutation.
//  - W only ranges 0..N-1; J always a value present in perm (no out-of-range ROM address).
// CONFIGURATION
//  JAM_PERM_CNT_EN defined: perm_cnt increments on each perm_last handshake, cleared on
//    start accept and reset, holds after done (N=8 final 40320).
//  Undefined: perm_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//  jam_pkg: JAM_N, JAM_IDX_W, jam_idx_t, perm_t (array of jam_idx_t [0:JAM_N-1]),
//    sched_state_e {IDLE,EMIT,NEXT,DONE}; also used by accumulator and bench.
//  Sub-module jam_next_perm: combinational perm_t in -> next perm_t out + is_last flag;
//    scheduler holds FSM, W counter, perm register, handshake.
// TESTING
//  1 Reset, start, addr_rdy=1: beats W=0..7 J=0..7 first/last on W=0/W=7; next assignment
//    J=0,1,2,3,4,5,7,6; NEXT cycle between shows addr_vld=0.
//  2 Full run addr_rdy=1, N=8: done one pulse at t+362880; last assignment J=7..0;
//    beat count 322560; bench scoreboard vs software cost model gives golden min/count.
//  3 Random addr_rdy 50%: W/J/flags stable while stalled; no beat lost or duplicated;
//    assignment sequence identical to case 2.
//  4 RST high during assignment 100 beat W=4: next cycle all outputs 0, IDLE; restart
//    begins at identity.
//  5 N=3: assignments 012,021,102,120,201,210 then done; perm_cnt=6 with JAM_PERM_CNT_EN.
//  6 start pulsed while busy and in DONE cycle: ignored, sequence and done unaffected.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared types for the job-assignment cost datapath (scheduler, accumulator, bench).
// No ports. Provides the index type, the permutation array type, the scheduler
// state encoding and an identity-permutation helper.
package jam_pkg;

   localparam int unsigned JAM_N     = 8;
   localparam int unsigned JAM_IDX_W = 3;

   typedef logic [JAM_IDX_W-1:0] jam_idx_t;
   typedef jam_idx_t perm_t [0:JAM_N-1];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      NEXT = 2'd2,
      DONE = 2'd3
   } sched_state_e;

   // Identity over the full storage width; slots at or above N are never read.
   function automatic perm_t identity_perm();
      perm_t p;
      for (int i = 0; i < int'(JAM_N); i++) begin
         p[i] = jam_idx_t'(i);
      end
      return p;
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational next-lexicographic-permutation step over the first N slots.
// Ports:
//   cur      in   perm_t  current permutation
//   nxt      out  perm_t  next permutation in lexicographic order
//   is_last  out  1       cur is descending (no successor; nxt is don't-care)
module jam_next_perm
   import jam_pkg::*;
#(
   parameter int unsigned N = JAM_N
) (
   input  perm_t cur,
   output perm_t nxt,
   output logic  is_last
);

   jam_idx_t piv;
   jam_idx_t swp;
   logic     has_piv;
   perm_t    swapped;

   // Pivot = rightmost ascent; swap target = rightmost element above the pivot
   // value; then the suffix after the pivot is reversed into ascending order.
   always_comb begin
      piv     = '0;
      swp     = '0;
      has_piv = 1'b0;
      for (int i = 0; i < int'(N) - 1; i++) begin
         if (cur[i] < cur[i+1]) begin
            piv     = jam_idx_t'(i);
            has_piv = 1'b1;
         end
      end
      for (int k = 0; k < int'(N); k++) begin
         if (k > int'(piv) && cur[k] > cur[piv]) begin
            swp = jam_idx_t'(k);
         end
      end
      swapped      = cur;
      swapped[piv] = cur[swp];
      swapped[swp] = cur[piv];
      nxt          = swapped;
      for (int j = 0; j < int'(N); j++) begin
         if (j > int'(piv)) begin
            nxt[j] = swapped[jam_idx_t'(int'(N) + int'(piv) - j)];
         end
      end
      is_last = ~has_piv;
   end

endmodule

// File: rtl/jam_perm_scheduler.sv
// Enumerates all N! worker->job assignments in lexicographic order and issues one
// (W, J=perm[W]) cost-ROM address per beat over a valid/ready handshake, framing
// each assignment with perm_first/perm_last and pulsing done after the last one.
// Optional build macro JAM_PERM_CNT_EN adds the perm_cnt assignment counter.
// Ports:
//   CLK         in   1      clock, rising edge
//   RST         in   1      synchronous active-high reset
//   start       in   1      begin enumeration (accepted only in IDLE)
//   W           out  IDX_W  worker index of current beat
//   J           out  IDX_W  job index perm[W]
//   addr_vld    out  1      W/J valid
//   addr_rdy    in   1      downstream accepts the beat
//   perm_first  out  1      beat is W=0
//   perm_last   out  1      beat is W=N-1
//   busy        out  1      scheduler not idle
//   done        out  1      one-cycle pulse after the final assignment
//   perm_cnt    out  16     completed assignments (JAM_PERM_CNT_EN only)
module jam_perm_scheduler
   import jam_pkg::*;
#(
   parameter int unsigned N     = JAM_N,
   parameter int unsigned IDX_W = JAM_IDX_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   output logic [IDX_W-1:0] W,
   output logic [IDX_W-1:0] J,
   output logic             addr_vld,
   input  logic             addr_rdy,
   output logic             perm_first,
   output logic             perm_last,
   output logic             busy,
   output logic             done
`ifdef JAM_PERM_CNT_EN
   ,
   output logic [15:0]      perm_cnt
`endif
);

   localparam jam_idx_t W_LAST = jam_idx_t'(N - 1);

   sched_state_e state, state_nxt;
   perm_t        perm, perm_nxt, perm_succ;
   jam_idx_t     w_q, w_nxt, j_q, j_nxt, w_inc;
   logic         vld_nxt, first_nxt, last_nxt, busy_nxt, done_nxt;
   logic         perm_is_last;
   logic         xfer;

   assign xfer  = addr_vld & addr_rdy;
   assign w_inc = w_q + jam_idx_t'(1);
   assign W     = IDX_W'(w_q);
   assign J     = IDX_W'(j_q);

   jam_next_perm #(.N(N)) u_next_perm (
      .cur     (perm),
      .nxt     (perm_succ),
      .is_last (perm_is_last)
   );

   // State, permutation, index and all output flags are registered here.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         perm       <= identity_perm();
         w_q        <= '0;
         j_q        <= '0;
         addr_vld   <= 1'b0;
         perm_first <= 1'b0;
         perm_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         perm       <= perm_nxt;
         w_q        <= w_nxt;
         j_q        <= j_nxt;
         addr_vld   <= vld_nxt;
         perm_first <= first_nxt;
         perm_last  <= last_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // Next state plus the values the registered outputs take in that state.
   always_comb begin
      state_nxt = state;
      perm_nxt  = perm;
      w_nxt     = w_q;
      j_nxt     = j_q;
      vld_nxt   = 1'b0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (start) begin
               state_nxt = EMIT;
               perm_nxt  = identity_perm();
               w_nxt     = '0;
               j_nxt     = '0;
               vld_nxt   = 1'b1;
               first_nxt = 1'b1;
               last_nxt  = (W_LAST == '0);
               busy_nxt  = 1'b1;
            end
         end
         EMIT: begin
            vld_nxt   = 1'b1;
            first_nxt = perm_first;
            last_nxt  = perm_last;
            if (xfer) begin
               if (w_q != W_LAST) begin
                  w_nxt     = w_inc;
                  j_nxt     = perm[w_inc];
                  first_nxt = 1'b0;
                  last_nxt  = (w_inc == W_LAST);
               end else begin
                  vld_nxt   = 1'b0;
                  first_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  if (perm_is_last) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = NEXT;
                  end
               end
            end
         end
         NEXT: begin
            state_nxt = EMIT;
            perm_nxt  = perm_succ;
            w_nxt     = '0;
            j_nxt     = perm_succ[0];
            vld_nxt   = 1'b1;
            first_nxt = 1'b1;
            last_nxt  = (W_LAST == '0);
         end
         DONE: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

`ifdef JAM_PERM_CNT_EN
   // Completed-assignment counter; holds its final value after done.
   always_ff @(posedge CLK) begin
      if (RST) begin
         perm_cnt <= '0;
      end else if (state == IDLE && start) begin
         perm_cnt <= '0;
      end else if (xfer && perm_last) begin
         perm_cnt <= perm_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jam_perm_scheduler.sv
// Bench for jam_perm_scheduler: three instances (N=8, N=3, N=5) checked every
// cycle against a tuple-enumeration model of lexicographic permutation order,
// plus directed literal expectations.
module tb_jam_perm_scheduler;

   logic       clk;
   logic       rst   [3];
   logic       start [3];
   logic       rdy   [3];
   logic [2:0] w_o   [3];
   logic [2:0] j_o   [3];
   logic       vld   [3];
   logic       first [3];
   logic       last  [3];
   logic       busy  [3];
   logic       done  [3];
   logic [15:0] cnt  [3];

   int tests = 0;
   int fails = 0;

   // model state per instance
   int  mp       [3][8];
   int  mw       [3];
   int  nperm    [3];
   int  beats    [3];
   int  done_cnt [3];
   bit  active   [3];
   bit  prev_stall [3];
   int  pw [3], pj [3], pf [3], pl [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   jam_perm_scheduler #(.N(8), .IDX_W(3)) u_n8 (
      .CLK(clk), .RST(rst[0]), .start(start[0]), .W(w_o[0]), .J(j_o[0]),
      .addr_vld(vld[0]), .addr_rdy(rdy[0]), .perm_first(first[0]), .perm_last(last[0]),
      .busy(busy[0]), .done(done[0])
`ifdef JAM_PERM_CNT_EN
      , .perm_cnt(cnt[0])
`endif
   );

   jam_perm_scheduler #(.N(3), .IDX_W(3)) u_n3 (
      .CLK(clk), .RST(rst[1]), .start(start[1]), .W(w_o[1]), .J(j_o[1]),
      .addr_vld(vld[1]), .addr_rdy(rdy[1]), .perm_first(first[1]), .perm_last(last[1]),
      .busy(busy[1]), .done(done[1])
`ifdef JAM_PERM_CNT_EN
      , .perm_cnt(cnt[1])
`endif
   );

   jam_perm_scheduler #(.N(5), .IDX_W(3)) u_n5 (
      .CLK(clk), .RST(rst[2]), .start(start[2]), .W(w_o[2]), .J(j_o[2]),
      .addr_vld(vld[2]), .addr_rdy(rdy[2]), .perm_first(first[2]), .perm_last(last[2]),
      .busy(busy[2]), .done(done[2])
`ifdef JAM_PERM_CNT_EN
      , .perm_cnt(cnt[2])
`endif
   );

   function automatic int n_of(int d);
      case (d)
         0:       return 8;
         1:       return 3;
         default: return 5;
      endcase
   endfunction

   function automatic int fact(int n);
      int f = 1;
      for (int i = 2; i <= n; i++) f = f * i;
      return f;
   endfunction

   // Successor = next base-n digit tuple (counting upward) whose digits are distinct.
   function automatic void model_next(int d);
      int  n = n_of(d);
      bit  ok;
      do begin
         for (int i = n - 1; i >= 0; i--) begin
            if (mp[d][i] < n - 1) begin
               mp[d][i] = mp[d][i] + 1;
               break;
            end
            mp[d][i] = 0;
         end
         ok = 1'b1;
         for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
               if (mp[d][a] == mp[d][b]) ok = 1'b0;
      end while (!ok);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   task automatic compare_cycle();
      for (int d = 0; d < 3; d++) begin
         int n = n_of(d);
         if (rst[d]) begin
            active[d]     = 1'b0;
            prev_stall[d] = 1'b0;
         end else begin
            if (prev_stall[d]) begin
               check($sformatf("stall_vld[%0d]", d), int'(vld[d]), 1);
               check($sformatf("stall_W[%0d]", d), int'(w_o[d]), pw[d]);
               check($sformatf("stall_J[%0d]", d), int'(j_o[d]), pj[d]);
               check($sformatf("stall_first[%0d]", d), int'(first[d]), pf[d]);
               check($sformatf("stall_last[%0d]", d), int'(last[d]), pl[d]);
            end
            if (vld[d] === 1'b1) begin
               if (!active[d]) begin
                  check($sformatf("vld_inactive[%0d]", d), int'(vld[d]), 0);
               end else begin
                  check($sformatf("W[%0d]", d), int'(w_o[d]), mw[d]);
                  check($sformatf("J[%0d]", d), int'(j_o[d]), mp[d][mw[d]]);
                  check($sformatf("first[%0d]", d), int'(first[d]), int'(mw[d] == 0));
                  check($sformatf("last[%0d]", d), int'(last[d]), int'(mw[d] == n - 1));
               end
            end
            if (done[d] === 1'b1) begin
               done_cnt[d]++;
               check($sformatf("done_all_issued[%0d]", d), nperm[d], fact(n));
               active[d] = 1'b0;
            end
            if (vld[d] === 1'b1 && rdy[d] && active[d]) begin
               beats[d]++;
               if (mw[d] == n - 1) begin
                  mw[d] = 0;
                  nperm[d]++;
                  if (nperm[d] < fact(n)) model_next(d);
               end else begin
                  mw[d]++;
               end
            end
            prev_stall[d] = (vld[d] === 1'b1) && !rdy[d];
            pw[d] = int'(w_o[d]);
            pj[d] = int'(j_o[d]);
            pf[d] = int'(first[d]);
            pl[d] = int'(last[d]);
            if (start[d] && busy[d] === 1'b0) begin
               for (int i = 0; i < 8; i++) mp[d][i] = i;
               mw[d]     = 0;
               nperm[d]  = 0;
               beats[d]  = 0;
               active[d] = 1'b1;
            end
         end
      end
   endtask

   int seq3 [32];
   int exp3 [18] = '{0,1,2, 0,2,1, 1,0,2, 1,2,0, 2,0,1, 2,1,0};
   int lit8 [8]  = '{0,1,2,3,4,5,7,6};

   initial begin
      int nb, done_at, ndone;
      bit got_done;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; rdy[d] = 1'b1;
         active[d] = 1'b0; prev_stall[d] = 1'b0; done_cnt[d] = 0;
         mw[d] = 0; nperm[d] = 0; beats[d] = 0;
      end
      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      // reset state
      tick(3);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      tick(1);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_W[%0d]", d), int'(w_o[d]), 0);
         check($sformatf("rst_J[%0d]", d), int'(j_o[d]), 0);
         check($sformatf("rst_vld[%0d]", d), int'(vld[d]), 0);
         check($sformatf("rst_flags[%0d]", d), int'({first[d], last[d]}), 0);
         check($sformatf("rst_busy_done[%0d]", d), int'({busy[d], done[d]}), 0);
`ifdef JAM_PERM_CNT_EN
         check($sformatf("rst_cnt[%0d]", d), int'(cnt[d]), 0);
`endif
      end

      // N=8: identity assignment, NEXT gap, second assignment
      start[0] = 1'b1;
      tick(1);
      start[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("n8_a0_vld", int'(vld[0]), 1);
         check("n8_a0_W", int'(w_o[0]), i);
         check("n8_a0_J", int'(j_o[0]), i);
         check("n8_a0_first", int'(first[0]), int'(i == 0));
         check("n8_a0_last", int'(last[0]), int'(i == 7));
         tick(1);
      end
      check("n8_next_vld", int'(vld[0]), 0);
      check("n8_next_busy", int'(busy[0]), 1);
      tick(1);
      for (int i = 0; i < 8; i++) begin
         check("n8_a1_J", int'(j_o[0]), lit8[i]);
         tick(1);
      end

      // N=8: reset during assignment 100 beat W=4, then restart from identity
      tick(904 - 17);
      check("n8_a100_W", int'(w_o[0]), 4);
      check("n8_a100_vld", int'(vld[0]), 1);
      rst[0] = 1'b1;
      tick(1);
      rst[0] = 1'b0;
      check("n8_abort_W_J", int'({w_o[0], j_o[0]}), 0);
      check("n8_abort_vld", int'(vld[0]), 0);
      check("n8_abort_flags", int'({first[0], last[0]}), 0);
      check("n8_abort_busy_done", int'({busy[0], done[0]}), 0);
      start[0] = 1'b1;
      tick(1);
      start[0] = 1'b0;
      check("n8_restart_J", int'(j_o[0]), 0);
      check("n8_restart_first", int'(first[0]), 1);
      tick(40);
      rst[0] = 1'b1;
      tick(1);
      rst[0] = 1'b0;
      check("n8_no_done", done_cnt[0], 0);

      // N=3: full sequence, start pulsed while busy and during DONE
      start[1] = 1'b1;
      tick(1);
      start[1] = 1'b0;
      nb = 0; done_at = -1; ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (vld[1] === 1'b1 && nb < 32) begin
            seq3[nb] = int'(j_o[1]);
            nb++;
         end
         if (done[1] === 1'b1) begin
            done_at = c;
            ndone++;
            start[1] = 1'b1;
         end else if (c == 5 || c == 13) begin
            start[1] = 1'b1;
         end else begin
            start[1] = 1'b0;
         end
         tick(1);
      end
      start[1] = 1'b0;
      check("n3_beats", nb, 18);
      for (int i = 0; i < 18; i++) check($sformatf("n3_seq%0d", i), seq3[i], exp3[i]);
      check("n3_done_pulses", ndone, 1);
      check("n3_done_cycle", done_at, 23);
      check("n3_idle_after", int'({busy[1], vld[1]}), 0);
`ifdef JAM_PERM_CNT_EN
      check("n3_perm_cnt", int'(cnt[1]), 6);
`endif

      // N=5 at full rate: done timing
      start[2] = 1'b1;
      tick(1);
      start[2] = 1'b0;
      done_at = -1;
      for (int c = 0; c < 1000; c++) begin
         if (done[2] === 1'b1) begin
            done_at = c;
            break;
         end
         tick(1);
      end
      check("n5_done_cycle", done_at, 719);
      check("n5_beats", beats[2], 600);
      tick(2);

      // N=5 with random backpressure
      start[2] = 1'b1;
      tick(1);
      start[2] = 1'b0;
      got_done = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rdy[2] = 1'($urandom_range(0, 1));
         tick(1);
         if (done[2] === 1'b1) begin
            got_done = 1'b1;
            break;
         end
      end
      rdy[2] = 1'b1;
      tick(2);
      check("n5r_done_seen", int'(got_done), 1);
      check("n5r_beats", beats[2], 600);
      check("n5r_assignments", nperm[2], 120);
      check("n5_done_total", done_cnt[2], 2);
      for (int i = 0; i < 5; i++) check($sformatf("n5_model_last%0d", i), mp[2][i], 4 - i);
`ifdef JAM_PERM_CNT_EN
      check("n5_perm_cnt", int'(cnt[2]), 120);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
